// File: rtl/rggen_wait_state_register.sv
// rggen_wait_state_register
// Multi-word register wrapper with programmable wait states between bus
// acceptance and completion. Decodes a WORDS-word window, steers the write
// mask into the addressed lane and issues one-cycle strobes to the bit fields.
// Optional feature macro: RGGEN_REGISTER_ERROR_RESPONSE_EN
//   defined   -> illegal accesses (read of a non-readable / write of a
//                non-writable register) answer RGGEN_SLAVE_ERROR
//   undefined -> illegal accesses answer RGGEN_OKAY (strobes still suppressed)
module rggen_wait_state_register #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter int                       WORDS         = 1,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       WAIT_CYCLES   = 0,
    parameter bit                       READABLE      = 1'b1,
    parameter bit                       WRITABLE      = 1'b1
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             request,
    input  logic [ADDRESS_WIDTH-1:0]         address,
    input  logic                             direction,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [DATA_WIDTH-1:0]            write_mask,
    output logic                             select,
    output logic                             ready,
    output logic [1:0]                       status,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic [WORDS*DATA_WIDTH-1:0]      value,
    output logic                             bf_write_access,
    output logic                             bf_read_access,
    output logic [WORDS*DATA_WIDTH-1:0]      bf_write_data,
    output logic [WORDS*DATA_WIDTH-1:0]      bf_write_mask,
    input  logic [WORDS*DATA_WIDTH-1:0]      bf_read_data,
    input  logic [WORDS*DATA_WIDTH-1:0]      bf_value
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW1   = ADDRESS_WIDTH + 1;

    // Compare in one extra bit so a window ending at the top of the address
    // space does not wrap.
    localparam logic [ADDRESS_WIDTH-1:0] LP_LOW_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);
    localparam logic [AW1-1:0]           LP_LO       = {1'b0, START_ADDRESS};
    localparam logic [AW1-1:0]           LP_HI       = LP_LO + AW1'(WORDS * BYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [7:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    localparam logic [1:0] RGGEN_OKAY  = 2'b00;
    localparam logic       RGGEN_WRITE = 1'b1;
`ifdef RGGEN_REGISTER_ERROR_RESPONSE_EN
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
    localparam logic [1:0] LP_ILLEGAL_STATUS = RGGEN_SLAVE_ERROR;
`else
    localparam logic [1:0] LP_ILLEGAL_STATUS = RGGEN_OKAY;
`endif

    logic [1:0]            r_state;
    logic [7:0]            r_cnt;
    logic [IW-1:0]         r_idx;
    logic                  r_dir;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_wmask;

    logic [AW1-1:0]        w_aligned;
    logic                  w_hit;
    logic [IW-1:0]         w_idx;
    logic                  w_access;
    logic                  w_legal;

    // Address decode: byte-lane bits are dropped before the window compare
    assign w_aligned = {1'b0, address & ~LP_LOW_MASK};
    assign w_hit     = (w_aligned >= LP_LO) && (w_aligned < LP_HI);
    assign select    = w_hit;

    if (WORDS == 1) begin : g_single_word
        assign w_idx = '0;
    end else begin : g_multi_word
        assign w_idx = IW'((w_aligned - LP_LO) >> LSB);
    end

    // Control FSM: capture request, count wait states, complete for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_dir   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (request && w_hit) begin
                        r_idx   <= w_idx;
                        r_dir   <= direction;
                        r_wdata <= write_data;
                        r_wmask <= write_mask;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_CNT_INIT;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    // A withdrawn request aborts silently: no strobe, no ready
                    if (!request) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_legal  = (r_dir == RGGEN_WRITE) ? WRITABLE : READABLE;

    assign ready           = w_access;
    assign bf_write_access = w_access && (r_dir == RGGEN_WRITE) && WRITABLE;
    assign bf_read_access  = w_access && (r_dir != RGGEN_WRITE) && READABLE;
    assign status          = (w_access && !w_legal) ? LP_ILLEGAL_STATUS : RGGEN_OKAY;
    assign read_data       = bf_read_access ? bf_read_data[r_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign value         = bf_value;
    assign bf_write_data = {WORDS{r_wdata}};

    // Write mask lives only in the captured lane so other words are untouched
    for (genvar k = 0; k < WORDS; k++) begin : g_lane
        assign bf_write_mask[k*DATA_WIDTH +: DATA_WIDTH] = (r_idx == IW'(k)) ? r_wmask : '0;
    end

endmodule

// File: tb/tb_rggen_wait_state_register.sv
// Bench for rggen_wait_state_register: three 2-word instances with different
// wait counts and access rights, directed cases plus randomized transactions
// checked against a cycle-count/arithmetic reference model.
module tb_rggen_wait_state_register;

    localparam logic [15:0] START = 16'h0100;
    localparam int WAITS [3] = '{0, 3, 5};
    localparam bit RDBL  [3] = '{1'b1, 1'b1, 1'b0};
    localparam bit WRBL  [3] = '{1'b1, 1'b0, 1'b1};
`ifdef RGGEN_REGISTER_ERROR_RESPONSE_EN
    localparam logic [1:0] ERR_STATUS = 2'b10;
`else
    localparam logic [1:0] ERR_STATUS = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic [15:0] address;
    logic        direction;
    logic [31:0] write_data, write_mask;
    logic [63:0] bf_rd, bf_val;

    logic        sel [3], rdy [3], bwa [3], bra [3];
    logic [1:0]  st  [3];
    logic [31:0] rd  [3];
    logic [63:0] val [3], bwd [3], bwm [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rggen_wait_state_register #(
            .ADDRESS_WIDTH (16),
            .START_ADDRESS (START),
            .WORDS         (2),
            .DATA_WIDTH    (32),
            .WAIT_CYCLES   (WAITS[g]),
            .READABLE      (RDBL[g]),
            .WRITABLE      (WRBL[g])
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .request         (req[g]),
            .address         (address),
            .direction       (direction),
            .write_data      (write_data),
            .write_mask      (write_mask),
            .select          (sel[g]),
            .ready           (rdy[g]),
            .status          (st[g]),
            .read_data       (rd[g]),
            .value           (val[g]),
            .bf_write_access (bwa[g]),
            .bf_read_access  (bra[g]),
            .bf_write_data   (bwd[g]),
            .bf_write_mask   (bwm[g]),
            .bf_read_data    (bf_rd),
            .bf_value        (bf_val)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus transaction on instance u; drop_at>0 withdraws the request after
    // that many clock edges. Expectations come from the decode window, the
    // 1+WAIT latency rule and the access rights of the instance.
    task automatic run_txn(input int u, input logic [15:0] a, input logic d,
                           input logic [31:0] wd, input logic [31:0] wm, input int drop_at);
        bit hit, legal, fire;
        int idx, lat, ncyc;
        hit   = (a >= START) && (a < START + 16'd8);
        idx   = hit ? int'((a - START) / 16'd4) : 0;
        lat   = 1 + WAITS[u];
        legal = d ? WRBL[u] : RDBL[u];
        ncyc  = hit ? lat + 2 : 10;
        address = a; direction = d; write_data = wd; write_mask = wm;
        req[u]  = 1'b1;
        #1;
        chk($sformatf("select[%0d] a=%0h", u, a), 64'(sel[u]), 64'(hit));
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            fire = hit && (drop_at == 0) && (n == lat);
            chk($sformatf("ready[%0d] cyc%0d", u, n), 64'(rdy[u]), 64'(fire));
            chk($sformatf("wr_strobe[%0d] cyc%0d", u, n), 64'(bwa[u]), 64'(fire && d && legal));
            chk($sformatf("rd_strobe[%0d] cyc%0d", u, n), 64'(bra[u]), 64'(fire && !d && legal));
            if (fire) begin
                chk($sformatf("status[%0d]", u), 64'(st[u]), legal ? 64'd0 : 64'(ERR_STATUS));
                chk($sformatf("read_data[%0d]", u), 64'(rd[u]),
                    (legal && !d) ? 64'(bf_rd[idx*32 +: 32]) : 64'd0);
                chk($sformatf("bf_write_data[%0d]", u), bwd[u], {wd, wd});
                chk($sformatf("bf_write_mask[%0d]", u), bwm[u],
                    (idx == 1) ? {wm, 32'h0} : {32'h0, wm});
                chk($sformatf("value[%0d]", u), val[u], bf_val);
                req[u] = 1'b0;
            end
            if (n == drop_at) req[u] = 1'b0;
        end
        req[u] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) req[u] = 1'b0;
        address = '0; direction = 1'b0; write_data = '0; write_mask = '0;
        bf_rd = '0; bf_val = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst ready[%0d]", u), 64'(rdy[u]), 64'd0);
            chk($sformatf("rst status[%0d]", u), 64'(st[u]), 64'd0);
            chk($sformatf("rst read_data[%0d]", u), 64'(rd[u]), 64'd0);
            chk($sformatf("rst strobes[%0d]", u), 64'({bwa[u], bra[u]}), 64'd0);
            chk($sformatf("rst bf_write_mask[%0d]", u), bwm[u], 64'd0);
            chk($sformatf("rst bf_write_data[%0d]", u), bwd[u], 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        bf_rd  = {32'hDEADBEEF, 32'h12345678};
        bf_val = {$urandom, $urandom};
        // WAIT=0 write to word 1
        run_txn(0, START + 16'd4, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 0);
        // WAIT=3 read of word 0
        run_txn(1, START, 1'b0, $urandom, $urandom, 0);
        // just past the window: no hit
        run_txn(0, START + 16'd8, 1'b1, $urandom, $urandom, 0);
        // write to a non-writable register
        run_txn(1, START + 16'd4, 1'b1, $urandom, $urandom, 0);
        // read of a non-readable register
        run_txn(2, START + 16'd4, 1'b0, $urandom, $urandom, 0);
        // WAIT=5: abort at cycle 2, then a fresh request
        run_txn(2, START, 1'b1, $urandom, $urandom, 2);
        run_txn(2, START, 1'b1, $urandom, $urandom, 0);

        // Reset in the middle of the wait phase with the request still held
        address = START; direction = 1'b0; req[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst ready", 64'(rdy[1]), 64'd0);
        chk("mid-rst strobes", 64'({bwa[1], bra[1]}), 64'd0);
        rst = 1'b0;
        run_txn(1, START, 1'b0, $urandom, $urandom, 0);

        // Randomized transactions around and inside the window
        for (int i = 0; i < 40; i++) begin
            int          u;
            logic [15:0] a;
            u      = $urandom_range(0, 2);
            a      = START - 16'd4 + 16'($urandom_range(0, 15));
            bf_rd  = {$urandom, $urandom};
            bf_val = {$urandom, $urandom};
            run_txn(u, a, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
